// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
//   Data-memory front end for the MEM stage of the pipelined CPU. Stores are
//   formatted into lane-replicated word writes with byte enables and queued
//   in a DEPTH-entry FIFO that drains to a word-wide req/ack memory bus.
//   Loads use the same bus and come back sign- or zero-extended on Data_in.
//   stall is raised whenever the current access cannot complete this cycle.
//
//   Optional feature: define DMEM_FWD_EN to enable store-to-load forwarding
//   from the youngest matching queued store when its byte enables cover the
//   load. Without it, any queued store to the same word blocks the load
//   until that store has drained.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   mem_w, mem_r          MEM-stage store / load request (never both high)
//   Addr_out, Data_out    byte address, right-aligned store data
//   dm_ctrl               0 word, 1 half, 2 half-unsigned, 3 byte, 4 byte-unsigned
//   Data_in               extended load result (holds outside a load response)
//   stall                 freeze the pipeline this cycle
//   bus_req, bus_we       bus request, 1 = write
//   bus_addr, bus_wdata   word address, lane-replicated write data
//   bus_be                byte enables
//   bus_rdata, bus_ack    read data, request completion

module dmem_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_w,
  input  logic        mem_r,
  input  logic [31:0] Addr_out,
  input  logic [31:0] Data_out,
  input  logic [2:0]  dm_ctrl,
  output logic [31:0] Data_in,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        data_in_q, data_in_d;
  logic [29:0]        ent_addr_q  [DEPTH];
  logic [29:0]        ent_addr_d  [DEPTH];
  logic [31:0]        ent_wdata_q [DEPTH];
  logic [31:0]        ent_wdata_d [DEPTH];
  logic [3:0]         ent_be_q    [DEPTH];
  logic [3:0]         ent_be_d    [DEPTH];

  logic               push;
  logic               pop;
  logic               full;
  logic [31:0]        st_wdata;
  logic [3:0]         st_be;
  logic [3:0]         ld_need;
  logic               match_any;
  logic               fwd_hit;
  logic [31:0]        fwd_data;

  // Extract and extend the addressed half/byte of a memory word.
  function automatic logic [31:0] load_format(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  ctrl);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [31:0] res;
    half_v = lane[1] ? word[31:16] : word[15:0];
    byte_v = word[{lane, 3'b000} +: 8];
    case (ctrl)
      3'd1:    res = {{16{half_v[15]}}, half_v};
      3'd2:    res = {16'h0000, half_v};
      3'd3:    res = {{24{byte_v[7]}}, byte_v};
      3'd4:    res = {24'h000000, byte_v};
      default: res = word;
    endcase
    return res;
  endfunction

  // Byte lanes an access of the given size touches.
  function automatic logic [3:0] lane_mask(input logic [1:0] lane,
                                           input logic [2:0] ctrl);
    logic [3:0] m;
    case (ctrl)
      3'd1, 3'd2: m = lane[1] ? 4'b1100 : 4'b0011;
      3'd3, 3'd4: m = 4'b0001 << lane;
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

  // Store formatting: replicate the sub-word across all lanes so the bus
  // only has to honour bus_be; low address bits beyond the size are ignored.
  always_comb begin
    st_be = lane_mask(Addr_out[1:0], dm_ctrl);
    case (dm_ctrl)
      3'd1, 3'd2: st_wdata = {2{Data_out[15:0]}};
      3'd3, 3'd4: st_wdata = {4{Data_out[7:0]}};
      default:    st_wdata = Data_out;
    endcase
    ld_need = lane_mask(Addr_out[1:0], dm_ctrl);
  end

  // Scan valid entries oldest to youngest; the last hit is the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
`ifdef DMEM_FWD_EN
    logic [31:0]      young_wdata;
    logic [3:0]       young_be;
    young_wdata = '0;
    young_be    = '0;
`endif
    idx       = '0;
    match_any = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (ent_addr_q[idx] == Addr_out[31:2])) begin
        match_any = 1'b1;
`ifdef DMEM_FWD_EN
        young_wdata = ent_wdata_q[idx];
        young_be    = ent_be_q[idx];
`endif
      end
    end
`ifdef DMEM_FWD_EN
    // Forward only from the youngest match, and only if it holds every byte.
    fwd_hit  = mem_r && (state_q == S_IDLE) && match_any &&
               ((young_be & ld_need) == ld_need);
    fwd_data = load_format(young_wdata, Addr_out[1:0], dm_ctrl);
`else
    fwd_hit  = 1'b0;
    fwd_data = '0;
`endif
  end

  // FIFO bookkeeping. Fullness is judged on the registered count, so a pop
  // in the same cycle does not let a stalled store in until the next cycle.
  always_comb begin
    full        = (count_q == CNT_W'(DEPTH));
    push        = mem_w && !full;
    pop         = (state_q == S_WR) && bus_ack;
    head_d      = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d      = push ? tail_q + PTR_W'(1) : tail_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    ent_addr_d  = ent_addr_q;
    ent_wdata_d = ent_wdata_q;
    ent_be_d    = ent_be_q;
    if (push) begin
      ent_addr_d[tail_q]  = Addr_out[31:2];
      ent_wdata_d[tail_q] = st_wdata;
      ent_be_d[tail_q]    = st_be;
    end
  end

  // Bus sequencer. Unblocked loads go ahead of queued stores; a blocked
  // load keeps the FSM draining until no matching entry remains.
  always_comb begin
    state_d   = state_q;
    data_in_d = data_in_q;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_be    = '0;
    case (state_q)
      S_IDLE: begin
        if (mem_r && !match_any) begin
          state_d = S_RD;
        end else if (count_q != '0) begin
          state_d = S_WR;
        end
        if (fwd_hit) begin
          data_in_d = fwd_data;
        end
      end
      S_WR: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = {ent_addr_q[head_q], 2'b00};
        bus_wdata = ent_wdata_q[head_q];
        bus_be    = ent_be_q[head_q];
        if (bus_ack) begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        bus_req  = 1'b1;
        bus_addr = {Addr_out[31:2], 2'b00};
        bus_be   = ld_need;
        if (bus_ack) begin
          data_in_d = load_format(bus_rdata, Addr_out[1:0], dm_ctrl);
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    stall   = (mem_w && full) || (mem_r && (state_q != S_RESP) && !fwd_hit);
    Data_in = fwd_hit ? fwd_data : data_in_q;
  end

  // State registers; reset discards all queued stores.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      data_in_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i]  <= '0;
        ent_wdata_q[i] <= '0;
        ent_be_q[i]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      data_in_q <= data_in_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i]  <= ent_addr_d[i];
        ent_wdata_q[i] <= ent_wdata_d[i];
        ent_be_q[i]    <= ent_be_d[i];
      end
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed testbench for dmem_store_buffer (DEPTH = 4). Inputs are driven
// just after the falling edge and outputs sampled 1 time unit later, well
// clear of the rising edge where the DUT updates.

module tb_dmem_store_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_w;
   logic        mem_r;
   logic [31:0] Addr_out;
   logic [31:0] Data_out;
   logic [2:0]  dm_ctrl;
   logic [31:0] Data_in;
   logic        stall;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   int vectorCount = 0;
   int missCount   = 0;

   dmem_store_buffer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_w     (mem_w),
      .mem_r     (mem_r),
      .Addr_out  (Addr_out),
      .Data_out  (Data_out),
      .dm_ctrl   (dm_ctrl),
      .Data_in   (Data_in),
      .stall     (stall),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_be    (bus_be),
      .bus_rdata (bus_rdata),
      .bus_ack   (bus_ack)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   // Single comparison point: counts every vector and reports a miscompare
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive one cycle's worth of inputs, then let combinational outputs settle
   task automatic applyStimulus(input logic w, input logic r, input logic [31:0] addr,
                                input logic [31:0] data, input logic [2:0] ctrl,
                                input logic ack, input logic [31:0] rdata);
      mem_w     = w;
      mem_r     = r;
      Addr_out  = addr;
      Data_out  = data;
      dm_ctrl   = ctrl;
      bus_ack   = ack;
      bus_rdata = rdata;
      #1;
   endtask

   // Advance to just after the next falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0);
   endtask

   // Store into an empty buffer, then watch it drain as one bus write
   task automatic doStore(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] ctrl, input logic [31:0] expAddr,
                          input logic [31:0] expWdata, input logic [3:0] expBe);
      applyStimulus(1'b1, 1'b0, addr, data, ctrl, 1'b0, 32'h0);
      checkOutput({tag, "_pushStall"}, {31'h0, stall}, 32'd0);
      step();
      idleCycle();
      checkOutput({tag, "_idleReq"}, {31'h0, bus_req}, 32'd0);
      step();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h0);
      checkOutput({tag, "_wrReqWe"}, {30'h0, bus_req, bus_we}, 32'd3);
      checkOutput({tag, "_wrAddr"}, bus_addr, expAddr);
      checkOutput({tag, "_wrData"}, bus_wdata, expWdata);
      checkOutput({tag, "_wrBe"}, {28'h0, bus_be}, {28'h0, expBe});
      step();
      idleCycle();
      checkOutput({tag, "_doneReq"}, {31'h0, bus_req}, 32'd0);
      step();
   endtask

   // Load with an empty buffer: IDLE -> RD (same-cycle ack) -> RESP
   task automatic doLoad(input string tag, input logic [31:0] addr, input logic [2:0] ctrl,
                         input logic [31:0] expAddr, input logic [31:0] rdata,
                         input logic [31:0] expData);
      applyStimulus(1'b0, 1'b1, addr, 32'h0, ctrl, 1'b0, 32'h0);
      checkOutput({tag, "_idleStall"}, {31'h0, stall}, 32'd1);
      step();
      applyStimulus(1'b0, 1'b1, addr, 32'h0, ctrl, 1'b1, rdata);
      checkOutput({tag, "_rdReqWe"}, {30'h0, bus_req, bus_we}, 32'd2);
      checkOutput({tag, "_rdAddr"}, bus_addr, expAddr);
      step();
      applyStimulus(1'b0, 1'b1, addr, 32'h0, ctrl, 1'b0, 32'h0);
      checkOutput({tag, "_respStall"}, {31'h0, stall}, 32'd0);
      checkOutput({tag, "_data"}, Data_in, expData);
      step();
      idleCycle();
      checkOutput({tag, "_hold"}, Data_in, expData);
      step();
   endtask

   // Store then a load to the same word that must wait for the store to drain
   task automatic doBlockedLoad(input string tag, input logic [31:0] stAddr,
                                input logic [31:0] stData, input logic [2:0] stCtrl,
                                input logic [31:0] expWaddr, input logic [31:0] expWdata,
                                input logic [3:0] expBe, input logic [31:0] ldAddr,
                                input logic [2:0] ldCtrl, input logic [31:0] rdata,
                                input logic [31:0] expData);
      applyStimulus(1'b1, 1'b0, stAddr, stData, stCtrl, 1'b0, 32'h0);
      checkOutput({tag, "_pushStall"}, {31'h0, stall}, 32'd0);
      step();
      applyStimulus(1'b0, 1'b1, ldAddr, 32'h0, ldCtrl, 1'b0, 32'h0);
      checkOutput({tag, "_blockStall"}, {31'h0, stall}, 32'd1);
      checkOutput({tag, "_blockReq"}, {31'h0, bus_req}, 32'd0);
      step();
      applyStimulus(1'b0, 1'b1, ldAddr, 32'h0, ldCtrl, 1'b1, 32'h0);
      checkOutput({tag, "_wrReqWe"}, {30'h0, bus_req, bus_we}, 32'd3);
      checkOutput({tag, "_wrAddr"}, bus_addr, expWaddr);
      checkOutput({tag, "_wrData"}, bus_wdata, expWdata);
      checkOutput({tag, "_wrBe"}, {28'h0, bus_be}, {28'h0, expBe});
      checkOutput({tag, "_wrStall"}, {31'h0, stall}, 32'd1);
      step();
      applyStimulus(1'b0, 1'b1, ldAddr, 32'h0, ldCtrl, 1'b0, 32'h0);
      checkOutput({tag, "_gapStall"}, {31'h0, stall}, 32'd1);
      step();
      applyStimulus(1'b0, 1'b1, ldAddr, 32'h0, ldCtrl, 1'b1, rdata);
      checkOutput({tag, "_rdReqWe"}, {30'h0, bus_req, bus_we}, 32'd2);
      checkOutput({tag, "_rdAddr"}, bus_addr, expWaddr);
      step();
      applyStimulus(1'b0, 1'b1, ldAddr, 32'h0, ldCtrl, 1'b0, 32'h0);
      checkOutput({tag, "_respStall"}, {31'h0, stall}, 32'd0);
      checkOutput({tag, "_data"}, Data_in, expData);
      step();
      idleCycle();
      step();
   endtask

   initial begin
      reset = 1'b1;
      mem_w = 1'b0; mem_r = 1'b0; Addr_out = '0; Data_out = '0; dm_ctrl = '0;
      bus_rdata = '0; bus_ack = 1'b0;
      #1;
      // Reset state
      checkOutput("rst_stall", {31'h0, stall}, 32'd0);
      checkOutput("rst_req", {31'h0, bus_req}, 32'd0);
      checkOutput("rst_we", {31'h0, bus_we}, 32'd0);
      checkOutput("rst_addr", bus_addr, 32'h0);
      checkOutput("rst_wdata", bus_wdata, 32'h0);
      checkOutput("rst_be", {28'h0, bus_be}, 32'h0);
      checkOutput("rst_data", Data_in, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Store formatting
      doStore("sb103",  32'h103, 32'h00000080, 3'd3, 32'h100, 32'h80808080, 4'b1000);
      doStore("sh106",  32'h106, 32'h0000BEEF, 3'd1, 32'h104, 32'hBEEFBEEF, 4'b1100);
      doStore("shu100", 32'h100, 32'hFFFF55AA, 3'd2, 32'h100, 32'h55AA55AA, 4'b0011);
      doStore("sw10B",  32'h10B, 32'h01234567, 3'd0, 32'h108, 32'h01234567, 4'b1111);
      doStore("sbu101", 32'h101, 32'h1234567F, 3'd4, 32'h100, 32'h7F7F7F7F, 4'b0010);

      // Load extension
      doLoad("lb103",  32'h103, 3'd3, 32'h100, 32'h80123456, 32'hFFFFFF80);
      doLoad("lh102",  32'h102, 3'd1, 32'h100, 32'h80010000, 32'hFFFF8001);
      doLoad("lhu100", 32'h100, 3'd2, 32'h100, 32'h1234ABCD, 32'h0000ABCD);
      doLoad("lh100",  32'h100, 3'd1, 32'h100, 32'h1234ABCD, 32'hFFFFABCD);
      doLoad("lbu101", 32'h101, 3'd4, 32'h100, 32'h0000F000, 32'h000000F0);
      doLoad("lb102",  32'h102, 3'd3, 32'h100, 32'h007F0000, 32'h0000007F);
      doLoad("lw10C",  32'h10C, 3'd0, 32'h10C, 32'h89ABCDEF, 32'h89ABCDEF);

      // Fill to DEPTH with ack held low, then one more store must stall
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h500 + 32'(4 * i), 32'h11110000 + 32'(i), 3'd0, 1'b0, 32'h0);
         checkOutput($sformatf("fill%0d_stall", i), {31'h0, stall}, 32'd0);
         step();
      end
      applyStimulus(1'b1, 1'b0, 32'h510, 32'h11110004, 3'd0, 1'b0, 32'h0);
      checkOutput("full_stall", {31'h0, stall}, 32'd1);
      checkOutput("full_head", bus_addr, 32'h500);
      step();
      applyStimulus(1'b1, 1'b0, 32'h510, 32'h11110004, 3'd0, 1'b1, 32'h0);
      checkOutput("full_popStall", {31'h0, stall}, 32'd1);
      step();
      applyStimulus(1'b1, 1'b0, 32'h510, 32'h11110004, 3'd0, 1'b0, 32'h0);
      checkOutput("full_land", {31'h0, stall}, 32'd0);
      step();
      applyStimulus(1'b1, 1'b0, 32'h514, 32'h0, 3'd0, 1'b0, 32'h0);
      checkOutput("full_again", {31'h0, stall}, 32'd1);
      step();
      for (int i = 1; i <= DEPTH; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h0);
         checkOutput($sformatf("drain%0d_reqWe", i), {30'h0, bus_req, bus_we}, 32'd3);
         checkOutput($sformatf("drain%0d_addr", i), bus_addr, 32'h500 + 32'(4 * i));
         checkOutput($sformatf("drain%0d_data", i), bus_wdata, 32'h11110000 + 32'(i));
         step();
         idleCycle();
         checkOutput($sformatf("drain%0d_idle", i), {31'h0, bus_req}, 32'd0);
         step();
      end
      idleCycle();
      checkOutput("drain_empty", {31'h0, bus_req}, 32'd0);
      step();

      // Unblocked load bypasses a queued store
      applyStimulus(1'b1, 1'b0, 32'h200, 32'hDEADBEEF, 3'd0, 1'b0, 32'h0);
      step();
      applyStimulus(1'b0, 1'b1, 32'h300, 32'h0, 3'd0, 1'b0, 32'h0);
      checkOutput("byp_idleStall", {31'h0, stall}, 32'd1);
      checkOutput("byp_idleReq", {31'h0, bus_req}, 32'd0);
      step();
      applyStimulus(1'b0, 1'b1, 32'h300, 32'h0, 3'd0, 1'b1, 32'hCAFEF00D);
      checkOutput("byp_rdReqWe", {30'h0, bus_req, bus_we}, 32'd2);
      checkOutput("byp_rdAddr", bus_addr, 32'h300);
      step();
      applyStimulus(1'b0, 1'b1, 32'h300, 32'h0, 3'd0, 1'b0, 32'h0);
      checkOutput("byp_respStall", {31'h0, stall}, 32'd0);
      checkOutput("byp_data", Data_in, 32'hCAFEF00D);
      step();
      idleCycle();
      checkOutput("byp_idleAfter", {31'h0, bus_req}, 32'd0);
      step();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h0);
      checkOutput("byp_wrReqWe", {30'h0, bus_req, bus_we}, 32'd3);
      checkOutput("byp_wrAddr", bus_addr, 32'h200);
      checkOutput("byp_wrData", bus_wdata, 32'hDEADBEEF);
      step();
      idleCycle();
      step();

`ifdef DMEM_FWD_EN
      // Covered load is forwarded in the same cycle; the store still drains
      applyStimulus(1'b1, 1'b0, 32'h202, 32'hABCD1234, 3'd1, 1'b0, 32'h0);
      step();
      applyStimulus(1'b0, 1'b1, 32'h202, 32'h0, 3'd2, 1'b0, 32'h0);
      checkOutput("fwd_stall", {31'h0, stall}, 32'd0);
      checkOutput("fwd_data", Data_in, 32'h00001234);
      checkOutput("fwd_noReq", {31'h0, bus_req}, 32'd0);
      step();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h0);
      checkOutput("fwd_wrReqWe", {30'h0, bus_req, bus_we}, 32'd3);
      checkOutput("fwd_wrData", bus_wdata, 32'h12341234);
      checkOutput("fwd_hold", Data_in, 32'h00001234);
      step();
      idleCycle();
      step();
`else
      // Matching store blocks the load until its write is acknowledged
      doBlockedLoad("blk202", 32'h202, 32'hABCD1234, 3'd1, 32'h200, 32'h12341234, 4'b1100,
                    32'h202, 3'd2, 32'h1234BEEF, 32'h00001234);
`endif

      // Byte store cannot cover a word load: wait for drain then read
      doBlockedLoad("cov204", 32'h204, 32'h000000A5, 3'd3, 32'h204, 32'hA5A5A5A5, 4'b0001,
                    32'h204, 3'd0, 32'h112233A5, 32'h112233A5);

      // Reset mid-WR with two entries queued
      applyStimulus(1'b1, 1'b0, 32'h400, 32'h00000010, 3'd0, 1'b0, 32'h0);
      step();
      applyStimulus(1'b1, 1'b0, 32'h404, 32'h00000020, 3'd0, 1'b0, 32'h0);
      step();
      idleCycle();
      checkOutput("rstWr_req", {31'h0, bus_req}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rstWr_reqDrop", {31'h0, bus_req}, 32'd0);
      step();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         idleCycle();
         checkOutput($sformatf("rstWr_empty%0d_req", i), {31'h0, bus_req}, 32'd0);
         checkOutput($sformatf("rstWr_empty%0d_stall", i), {31'h0, stall}, 32'd0);
         step();
      end
      // Queued stores are gone: the next write on the bus is the new one
      doStore("postRst", 32'h600, 32'h600DF00D, 3'd0, 32'h600, 32'h600DF00D, 4'b1111);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
